// File: rtl/resq_dispatch_arbiter.sv
// ---------------------------------------------------------------------------
// resq_dispatch_arbiter
//   N-channel relief dispatcher. Each channel owns a circular FIFO of requests
//   {zone, priority, age, cancel}. The emergency channel preempts everything,
//   and an insert into it cancels same-zone entries queued elsewhere. The other
//   channels arbitrate by aging boost, then priority, then lowest index. The
//   winner lands in a registered valid/ready output stage.
//
// Ports
//   Clock, Reset_Queue              clock, synchronous active-high reset
//   Insert/Resource_line/Zone/Priority  one insert per cycle into a channel
//   Threshold                       age at which a queued head is boosted
//   Out_Ready                       consumer accepts the output stage
//   Out_Valid/Zone/Priority/Resource/Boost  registered output stage
//   Full, Empty                     per-channel FIFO status (tombstones occupy)
//   Insert_Drop                     1-cycle pulse after a rejected insert
// ---------------------------------------------------------------------------

// Per-channel FIFO. Entries keep their own age and cancel flag; a cancelled
// entry stays in place as a tombstone until it reaches the head.
module resq_chan_fifo #(
  parameter int DEPTH  = 8,
  parameter int ZONE_W = 8,
  parameter int PRIO_W = 2,
  parameter int AGE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ZONE_W-1:0] push_zone,
  input  logic [PRIO_W-1:0] push_prio,
  input  logic              pop,
  input  logic              cancel,
  input  logic [ZONE_W-1:0] cancel_zone,
  input  logic [AGE_W-1:0]  threshold,
  output logic [ZONE_W-1:0] head_zone,
  output logic [PRIO_W-1:0] head_prio,
  output logic              head_kill,
  output logic              head_boost,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ZONE_W-1:0] zone_q;
  logic [DEPTH-1:0][PRIO_W-1:0] prio_q;
  logic [DEPTH-1:0][AGE_W-1:0]  age_q;
  logic [DEPTH-1:0]             occ_q;
  logic [DEPTH-1:0]             kill_q;
  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [PW:0]                  count;

  assign head_zone  = zone_q[rd_ptr];
  assign head_prio  = prio_q[rd_ptr];
  assign head_kill  = kill_q[rd_ptr];
  assign head_boost = age_q[rd_ptr] >= threshold;
  assign full       = count == (PW+1)'(DEPTH);
  assign empty      = count == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q <= '0;
      prio_q <= '0;
      age_q  <= '0;
      occ_q  <= '0;
      kill_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i]) begin
          if (age_q[i] != '1) age_q[i] <= age_q[i] + AGE_W'(1);
          if (cancel && zone_q[i] == cancel_zone) kill_q[i] <= 1'b1;
        end
      end
      if (pop) begin
        occ_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      // push is never issued when full and pop never when empty, so the
      // written slot can never be the slot being popped.
      if (push) begin
        zone_q[wr_ptr] <= push_zone;
        prio_q[wr_ptr] <= push_prio;
        age_q[wr_ptr]  <= '0;
        kill_q[wr_ptr] <= 1'b0;
        occ_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module resq_dispatch_arbiter #(
  parameter int NUM_RES  = 3,
  parameter int EMERG_CH = 2,
  parameter int DEPTH    = 8,
  parameter int ZONE_W   = 8,
  parameter int PRIO_W   = 2,
  parameter int AGE_W    = 8
) (
  input  logic                       Clock,
  input  logic                       Reset_Queue,
  input  logic                       Insert,
  input  logic [$clog2(NUM_RES)-1:0] Resource_line,
  input  logic [ZONE_W-1:0]          Zone,
  input  logic [PRIO_W-1:0]          Priority,
  input  logic [AGE_W-1:0]           Threshold,
  input  logic                       Out_Ready,
  output logic                       Out_Valid,
  output logic [ZONE_W-1:0]          Out_Zone,
  output logic [PRIO_W-1:0]          Out_Priority,
  output logic [$clog2(NUM_RES)-1:0] Out_Resource,
  output logic                       Out_Boost,
  output logic [NUM_RES-1:0]         Full,
  output logic [NUM_RES-1:0]         Empty,
  output logic                       Insert_Drop
);
  localparam int RW = $clog2(NUM_RES);

  logic [NUM_RES-1:0]             line_hit, push, pop, cancel;
  logic [NUM_RES-1:0]             h_kill, h_boost, cand, tomb;
  logic [NUM_RES-1:0][ZONE_W-1:0] h_zone;
  logic [NUM_RES-1:0][PRIO_W-1:0] h_prio;
  logic                           line_full, accept, load;
  logic                           have_win, win_boost;
  logic [RW-1:0]                  win;
  logic [ZONE_W-1:0]              win_zone;
  logic [PRIO_W-1:0]              win_prio;

  // Decode the target line; an out-of-range line hits nothing and is dropped.
  always_comb begin
    line_hit  = '0;
    line_full = 1'b0;
    for (int c = 0; c < NUM_RES; c++) begin
      if (Resource_line == RW'(c)) begin
        line_hit[c] = 1'b1;
        line_full   = Full[c];
      end
    end
  end

  assign accept = Insert && (|line_hit) && !line_full;
  assign push   = line_hit & {NUM_RES{accept}};
  assign load   = !Out_Valid || Out_Ready;

  genvar g;
  generate
    for (g = 0; g < NUM_RES; g++) begin : g_ch
      assign cancel[g] = (g != EMERG_CH) && push[EMERG_CH];
      resq_chan_fifo #(
        .DEPTH(DEPTH), .ZONE_W(ZONE_W), .PRIO_W(PRIO_W), .AGE_W(AGE_W)
      ) u_ch (
        .clk        (Clock),
        .rst        (Reset_Queue),
        .push       (push[g]),
        .push_zone  (Zone),
        .push_prio  (Priority),
        .pop        (pop[g]),
        .cancel     (cancel[g]),
        .cancel_zone(Zone),
        .threshold  (Threshold),
        .head_zone  (h_zone[g]),
        .head_prio  (h_prio[g]),
        .head_kill  (h_kill[g]),
        .head_boost (h_boost[g]),
        .full       (Full[g]),
        .empty      (Empty[g])
      );
    end
  endgenerate

  // Winner selection over pre-edge heads. Cancelled heads are tombstones:
  // they are popped on a load edge but never compete.
  always_comb begin
    have_win  = 1'b0;
    win       = '0;
    win_boost = 1'b0;
    win_zone  = '0;
    win_prio  = '0;
    tomb      = ~Empty & h_kill;
    cand      = ~Empty & ~h_kill;
    if (cand[EMERG_CH]) begin
      have_win = 1'b1;
      win      = RW'(EMERG_CH);
      win_zone = h_zone[EMERG_CH];
      win_prio = h_prio[EMERG_CH];
    end else begin
      for (int c = 0; c < NUM_RES; c++) begin
        if (!have_win && cand[c] && h_boost[c]) begin
          have_win  = 1'b1;
          win_boost = 1'b1;
          win       = RW'(c);
          win_zone  = h_zone[c];
          win_prio  = h_prio[c];
        end
      end
      if (!have_win) begin
        // strict '>' keeps the lowest index on priority ties
        for (int c = 0; c < NUM_RES; c++) begin
          if (cand[c] && (!have_win || h_prio[c] > win_prio)) begin
            have_win = 1'b1;
            win      = RW'(c);
            win_zone = h_zone[c];
            win_prio = h_prio[c];
          end
        end
      end
    end
    pop = '0;
    if (load) begin
      for (int c = 0; c < NUM_RES; c++)
        pop[c] = tomb[c] || (have_win && win == RW'(c));
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      Out_Valid    <= 1'b0;
      Out_Zone     <= '0;
      Out_Priority <= '0;
      Out_Resource <= '0;
      Out_Boost    <= 1'b0;
      Insert_Drop  <= 1'b0;
    end else begin
      Insert_Drop <= Insert && !accept;
      if (load) begin
        Out_Valid <= have_win;
        if (have_win) begin
          Out_Zone     <= win_zone;
          Out_Priority <= win_prio;
          Out_Resource <= win;
          Out_Boost    <= win_boost;
        end
      end
    end
  end
endmodule

// File: tb/tb_resq_dispatch_arbiter.sv
// Bench for resq_dispatch_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-level reference model.
module tb_resq_dispatch_arbiter;
  localparam int N = 3, EM = 2, D = 8;

  logic       Clock = 1'b0;
  logic       Reset_Queue = 1'b1;
  logic       Insert = 1'b0;
  logic [1:0] Resource_line = '0;
  logic [7:0] Zone = '0;
  logic [1:0] Priority = '0;
  logic [7:0] Threshold = 8'hFF;
  logic       Out_Ready = 1'b0;
  logic       Out_Valid, Out_Boost, Insert_Drop;
  logic [7:0] Out_Zone;
  logic [1:0] Out_Priority, Out_Resource;
  logic [2:0] Full, Empty;

  int checks = 0, errors = 0;

  resq_dispatch_arbiter dut (
    .Clock(Clock), .Reset_Queue(Reset_Queue), .Insert(Insert),
    .Resource_line(Resource_line), .Zone(Zone), .Priority(Priority),
    .Threshold(Threshold), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid),
    .Out_Zone(Out_Zone), .Out_Priority(Out_Priority),
    .Out_Resource(Out_Resource), .Out_Boost(Out_Boost), .Full(Full),
    .Empty(Empty), .Insert_Drop(Insert_Drop)
  );

  always #5 Clock = ~Clock;

  // Reference model: plain per-channel queues of requests.
  typedef struct packed {
    logic [7:0] zone;
    logic [1:0] prio;
    logic [7:0] age;
    logic       cxl;
  } ent_t;
  ent_t       m [N][D];
  int         n [N];
  logic       m_ov, m_boost, m_drop;
  logic [7:0] m_zone;
  logic [1:0] m_prio, m_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void mpop(input int c);
    for (int i = 0; i + 1 < n[c]; i++) m[c][i] = m[c][i+1];
    n[c]--;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit tomb [N];
    bit cand [N];
    int win, line;
    bit bst, acc, load;
    if (Reset_Queue) begin
      for (int c = 0; c < N; c++) n[c] = 0;
      m_ov = 0; m_zone = 0; m_prio = 0; m_res = 0; m_boost = 0; m_drop = 0;
      return;
    end
    line = int'(Resource_line);
    acc  = 0;
    if (Insert && line < N) acc = (n[line] < D);
    load = !m_ov || Out_Ready;
    if (load) begin
      win = -1; bst = 0;
      for (int c = 0; c < N; c++) begin
        tomb[c] = n[c] > 0 && m[c][0].cxl;
        cand[c] = n[c] > 0 && !m[c][0].cxl;
      end
      if (cand[EM]) win = EM;
      else begin
        for (int c = 0; c < N; c++)
          if (win < 0 && cand[c] && m[c][0].age >= Threshold) begin win = c; bst = 1; end
        if (win < 0)
          for (int c = 0; c < N; c++)
            if (cand[c] && (win < 0 || m[c][0].prio > m[win][0].prio)) win = c;
      end
      if (win >= 0) begin
        m_ov = 1; m_zone = m[win][0].zone; m_prio = m[win][0].prio;
        m_res = 2'(win); m_boost = bst;
        mpop(win);
      end else m_ov = 0;
      for (int c = 0; c < N; c++) if (tomb[c]) mpop(c);
    end
    for (int c = 0; c < N; c++)
      for (int i = 0; i < n[c]; i++) begin
        if (m[c][i].age != 8'hFF) m[c][i].age++;
        if (acc && line == EM && c != EM && m[c][i].zone == Zone) m[c][i].cxl = 1;
      end
    if (acc) begin
      m[line][n[line]] = '{zone: Zone, prio: Priority, age: 8'd0, cxl: 1'b0};
      n[line]++;
    end
    m_drop = Insert && !acc;
  endfunction

  task automatic check_all(input string tag);
    logic [2:0] ef, ee;
    for (int c = 0; c < N; c++) begin
      ef[c] = (n[c] == D);
      ee[c] = (n[c] == 0);
    end
    chk({tag, ".valid"}, Out_Valid, m_ov);
    chk({tag, ".full"}, Full, ef);
    chk({tag, ".empty"}, Empty, ee);
    chk({tag, ".drop"}, Insert_Drop, m_drop);
    if (m_ov) begin
      chk({tag, ".zone"}, Out_Zone, m_zone);
      chk({tag, ".prio"}, Out_Priority, m_prio);
      chk({tag, ".res"}, Out_Resource, m_res);
      chk({tag, ".boost"}, Out_Boost, m_boost);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic ins,
                      input logic [1:0] line, input logic [7:0] z,
                      input logic [1:0] p, input logic rdy);
    Reset_Queue = rst; Insert = ins; Resource_line = line;
    Zone = z; Priority = p; Out_Ready = rdy;
    model_edge();
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, rdy);
  endtask

  initial begin
    bit seen;
    // T1 reset
    step("t1", 1, 0, 0, 0, 0, 0);
    step("t1", 1, 0, 0, 0, 0, 0);
    chk("t1_valid", Out_Valid, 0);
    chk("t1_empty", Empty, 3'b111);
    chk("t1_full", Full, 3'b000);
    chk("t1_drop", Insert_Drop, 0);

    // T2 preemption
    step("t2", 0, 1, 0, 8'h11, 3, 0);
    step("t2", 0, 1, 2, 8'h22, 0, 0);
    chk("t2_hold", Out_Zone, 8'h11);
    step("t2", 0, 1, 1, 8'h33, 3, 0);
    chk("t2_still", Out_Zone, 8'h11);
    idle("t2", 1);
    chk("t2_emerg_zone", Out_Zone, 8'h22);
    chk("t2_emerg_res", Out_Resource, 2'd2);
    idle("t2", 1);
    idle("t2", 1);

    // T3 priority then index tie-break (blocker holds the stage meanwhile)
    step("t3", 0, 1, 0, 8'hAA, 0, 0);
    step("t3", 0, 1, 0, 8'h01, 1, 0);
    step("t3", 0, 1, 1, 8'h02, 2, 0);
    idle("t3", 1);
    chk("t3_prio_first", Out_Zone, 8'h02);
    idle("t3", 1);
    chk("t3_prio_second", Out_Zone, 8'h01);
    idle("t3", 1);
    step("t3", 0, 1, 1, 8'hAB, 0, 0);
    step("t3", 0, 1, 0, 8'h03, 2, 0);
    step("t3", 0, 1, 1, 8'h04, 2, 0);
    idle("t3", 1);
    chk("t3_tie_first", Out_Zone, 8'h03);
    idle("t3", 1);
    chk("t3_tie_second", Out_Zone, 8'h04);
    idle("t3", 1);

    // T4 aging boost against a continuously refilled ch0
    Threshold = 8'd5;
    step("t4", 0, 1, 0, 8'hB0, 3, 0);
    step("t4", 0, 1, 0, 8'hB1, 3, 0);
    step("t4", 0, 1, 1, 8'h50, 0, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step("t4", 0, 1, 0, 8'hC0 + 8'(i), 3, 1);
      if (Out_Valid && Out_Zone == 8'h50) seen = Out_Boost;
    end
    chk("t4_boosted", seen, 1);
    Threshold = 8'hFF;
    for (int i = 0; i < 12; i++) idle("t4d", 1);

    // T5 cancellation
    step("t5", 0, 1, 1, 8'hBB, 0, 0);
    step("t5", 0, 1, 0, 8'h40, 0, 0);
    step("t5", 0, 1, 0, 8'h41, 0, 0);
    step("t5", 0, 1, 2, 8'h40, 0, 0);
    idle("t5", 1);
    chk("t5_first_zone", Out_Zone, 8'h40);
    chk("t5_first_res", Out_Resource, 2'd2);
    idle("t5", 1);
    chk("t5_second_zone", Out_Zone, 8'h41);
    chk("t5_second_res", Out_Resource, 2'd0);
    idle("t5", 1);
    chk("t5_drained", Out_Valid, 0);

    // T6 full / drop / bad line / reset mid-burst
    step("t6", 0, 1, 0, 8'hDD, 0, 0);
    for (int i = 0; i < 8; i++) step("t6", 0, 1, 1, 8'h70 + 8'(i), 1, 0);
    chk("t6_full", Full, 3'b010);
    step("t6", 0, 1, 1, 8'h7F, 1, 0);
    chk("t6_drop", Insert_Drop, 1);
    chk("t6_still_full", Full, 3'b010);
    idle("t6", 0);
    chk("t6_drop_pulse", Insert_Drop, 0);
    step("t6", 0, 1, 3, 8'h7E, 1, 0);
    chk("t6_bad_line", Insert_Drop, 1);
    step("t6", 1, 1, 0, 8'h7D, 1, 1);
    chk("t6_rst_empty", Empty, 3'b111);
    chk("t6_rst_valid", Out_Valid, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) Threshold = 8'($urandom_range(0, 24));
      step("rnd", ($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)), 8'h60 + 8'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
